// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter: state encodings,
// requester identifiers and default widths.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int ARB_ADDR_W   = 28;
  localparam int ARB_BLOCK_W  = 128;
  localparam int ARB_MAX_WAIT = 255;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie, the side that was not served
// last wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      grant_i = (last_grant == REQ_D);
      grant_d = (last_grant == REQ_I);
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refill/writeback.
// Optional stall/conflict performance counters are built when ARB_PERF_COUNT_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int BLOCK_W  = ARB_BLOCK_W,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDR,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDR,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic               PIPE_STALL,
`ifdef ARB_PERF_COUNT_EN
  output logic [31:0]        I_STALL_CYCLES,
  output logic [31:0]        D_STALL_CYCLES,
  output logic [31:0]        CONFLICT_CYCLES,
`endif
  output logic               ARB_ERROR
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t       state;
  logic             last_grant;
  logic             started;
  logic [CNT_W-1:0] wait_cnt;
  logic             d_req;
  logic             pick_i;
  logic             pick_d;
  logic             granted;
  logic             timeout;
  logic             complete;

  assign d_req = D_READ | D_WRITE;

  rr_pick2 u_pick (
    .req_i      (I_READ),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant_i    (pick_i),
    .grant_d    (pick_d)
  );

  // A transaction finishes on the first idle memory cycle after memory has
  // acknowledged with busy, or when the watchdog gives up on it.
  assign granted  = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
  assign timeout  = granted && MEM_BUSYWAIT && (wait_cnt == CNT_W'(MAX_WAIT - 1));
  assign complete = granted && ((started && !MEM_BUSYWAIT) || timeout);

  assign I_BUSYWAIT = I_READ && !(complete && (state == ARB_GRANT_I));
  assign D_BUSYWAIT = d_req && !(complete && (state == ARB_GRANT_D));
  assign PIPE_STALL = I_BUSYWAIT | D_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= ARB_IDLE;
      last_grant    <= REQ_D;
      started       <= 1'b0;
      wait_cnt      <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
      ARB_ERROR     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          started  <= 1'b0;
          wait_cnt <= '0;
          if (D_READ && D_WRITE) begin
            ARB_ERROR <= 1'b1;
          end
          if (pick_i) begin
            state     <= ARB_GRANT_I;
            MEM_ADDR  <= I_ADDR;
            MEM_READ  <= 1'b1;
            MEM_WRITE <= 1'b0;
          end else if (pick_d) begin
            // A conflicting read+write request is served as a write.
            state         <= ARB_GRANT_D;
            MEM_ADDR      <= D_ADDR;
            MEM_WRITEDATA <= D_WRITEDATA;
            MEM_WRITE     <= D_WRITE;
            MEM_READ      <= !D_WRITE;
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (MEM_BUSYWAIT) begin
            started  <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (complete) begin
            state     <= ARB_RELEASE;
            started   <= 1'b0;
            wait_cnt  <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (timeout) begin
              ARB_ERROR <= 1'b1;
            end
            if (state == ARB_GRANT_I) begin
              I_READDATA <= timeout ? '0 : MEM_READDATA;
              last_grant <= REQ_I;
            end else begin
              if (MEM_READ) begin
                D_READDATA <= timeout ? '0 : MEM_READDATA;
              end
              last_grant <= REQ_D;
            end
          end
        end
        ARB_RELEASE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_COUNT_EN
  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      I_STALL_CYCLES  <= '0;
      D_STALL_CYCLES  <= '0;
      CONFLICT_CYCLES <= '0;
    end else begin
      if (I_BUSYWAIT && (I_STALL_CYCLES != '1)) begin
        I_STALL_CYCLES <= I_STALL_CYCLES + 32'd1;
      end
      if (D_BUSYWAIT && (D_STALL_CYCLES != '1)) begin
        D_STALL_CYCLES <= D_STALL_CYCLES + 32'd1;
      end
      if ((state == ARB_IDLE) && I_READ && d_req && (CONFLICT_CYCLES != '1)) begin
        CONFLICT_CYCLES <= CONFLICT_CYCLES + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one main-memory port between the instruction-cache refill path (I side) and the data-cache refill/writeback path (D side).
- Generates per-requester busywait and the global pipeline stall that freezes the pipeline registers (IF_ID … MEM_WB) while either cache waits on memory.
- Sits between the two caches and main memory; sequences each transaction to completion before re-arbitrating.

Parameters:
ADDR_W, 28, block address width (word address minus block offset)
BLOCK_W, 128, memory block width in bits
MAX_WAIT, 255, watchdog limit on memory busywait cycles per transaction

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
I_READ  in  1  I-cache refill request, held until I_BUSYWAIT drops
I_ADDR  in  ADDR_W  I-cache block address
I_READDATA  out  BLOCK_W  block returned to I-cache
I_BUSYWAIT  out  1  I request pending/not complete
D_READ  in  1  D-cache refill request
D_WRITE  in  1  D-cache writeback request (D_READ and D_WRITE mutually exclusive)
D_ADDR  in  ADDR_W  D-cache block address
D_WRITEDATA  in  BLOCK_W  writeback block
D_READDATA  out  BLOCK_W  block returned to D-cache
D_BUSYWAIT  out  1  D request pending/not complete
MEM_READ  out  1  memory read strobe
MEM_WRITE  out  1  memory write strobe
MEM_ADDR  out  ADDR_W  memory block address
MEM_WRITEDATA  out  BLOCK_W  memory write block
MEM_READDATA  in  BLOCK_W  memory read block
MEM_BUSYWAIT  in  1  memory busy
PIPE_STALL  out  1  I_BUSYWAIT | D_BUSYWAIT, to pipeline-register BUSYWAIT inputs
ARB_ERROR  out  1  sticky watchdog/protocol error flag

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE; 2-bit state reg; LAST_GRANT bit (0=I, 1=D).
- Reset (RESET low, async): state=IDLE, LAST_GRANT=1 (I wins first tie), MEM_READ=MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0, I_READDATA=D_READDATA=0, ARB_ERROR=0, wait counter=0. Busywaits are combinational: D_BUSYWAIT=D_READ|D_WRITE, I_BUSYWAIT=I_READ. Reset mid-transaction abandons it; memory strobes drop immediately.
- IDLE: only I -> GRANT_I; only D -> GRANT_D; both -> side opposite LAST_GRANT (round-robin). No request -> stay.
- On entering GRANT_x (registered): latch address/data and assert MEM_READ (I or D read) or MEM_WRITE (D write). Memory strobes assert the cycle after the request is seen.
- Completion: in GRANT_x, first cycle with MEM_BUSYWAIT=0 after at least one MEM_BUSYWAIT=1 cycle (started flag). That cycle: x_BUSYWAIT=0 combinationally, x_READDATA <= MEM_READDATA at edge, strobes drop, LAST_GRANT=x, state -> RELEASE.
- RELEASE: one turnaround cycle, strobes low; requester deasserts its request; -> IDLE. Minimum transaction = 4 cycles request-to-release.
- Requester dropping request while granted: ignored; transaction completes, data discarded.
- Watchdog: wait counter increments each GRANT cycle with MEM_BUSYWAIT=1; reaching MAX_WAIT sets ARB_ERROR, forces completion (READDATA=0), -> RELEASE. D_READ&D_WRITE both high in IDLE sets ARB_ERROR; the write is served.
- Fairness: under continuous requests from both sides, grants alternate; neither waits more than one foreign transaction.

Optional Feature:
- Macro ARB_PERF_COUNT_EN.
- Defined: adds 32-bit saturating counters I_STALL_CYCLES, D_STALL_CYCLES (cycles each busywait is high) and CONFLICT_CYCLES (both requests pending in IDLE), exposed as outputs; cleared by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package arb_pkg: state encodings (ARB_IDLE=2'd0, ARB_GRANT_I=2'd1, ARB_GRANT_D=2'd2, ARB_RELEASE=2'd3), requester IDs, default widths.
- Sub-module rr_pick2: combinational 2-way round-robin selector (req_i, req_d, last_grant -> grant_i, grant_d).

Test Plan:
- Reset low mid-GRANT_D with MEM_WRITE=1 -> MEM_WRITE=0 same cycle, state IDLE, ARB_ERROR=0.
- I_READ alone, I_ADDR=0x0000010, memory busy 5 cycles, MEM_READDATA=0xA5..A5 -> MEM_READ high with MEM_ADDR=0x10, I_READDATA=0xA5..A5, I_BUSYWAIT low exactly at completion, PIPE_STALL tracks it.
- I_READ and D_READ asserted same cycle after reset -> I granted first, D next; D_BUSYWAIT high throughout I transaction.
- Continuous I and D requests for 6 transactions -> grants alternate I,D,I,D,I,D.
- D_WRITE with D_WRITEDATA=0x1234..., MEM_BUSYWAIT stuck high, MAX_WAIT=8 -> ARB_ERROR=1 after 8 wait cycles, D_BUSYWAIT released, state IDLE.
- ARB_PERF_COUNT_EN defined, one 3-cycle-busy I refill -> I_STALL_CYCLES equals observed I_BUSYWAIT-high cycle count.
